pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline hazard and stall controller for the 5-stage RV32 core.
//  Reads the ID/EX register's outputs (rd, memtoreg, regwrite), the ID-stage source registers,
//  the EX branch decision and the data-memory handshake.
//  Drives the write-enables, holds and flushes of PC, IF/ID, ID/EX and EX/MEM.
//  Also keeps stall/flush performance counters and a data-memory wait timeout.
// PARAMETERS
//  MEM_TIMEOUT  64  max cycles to wait for mem_ready before flagging a fault (>=2)
//  CNT_W        32  width of the performance counters (saturating)
// PORTS
//  clk             in   1      core clock, all state updates on rising edge
//  reset           in   1      asynchronous, active-high; clears FSM, wait counter and perf counters
//  id_rs1          in   5      rs1 of instruction in ID
//  id_rs2          in   5      rs2 of instruction in ID
//  id_uses_rs2     in   1      ID instruction reads rs2 (R/S/B types)
//  ex_rd           in   5      rd held in ID/EX
//  ex_memtoreg     in   1      ID/EX instruction is a load
//  ex_branch_taken in   1      EX resolved a taken branch/jump this cycle
//  mem_req         in   1      EX/MEM instruction accesses data memory
//  mem_ready       in   1      data memory completes the access this cycle
//  pc_write        out  1      PC may update
//  ifid_write      out  1      IF/ID may load
//  ifid_flush      out  1      clear IF/ID at the next edge
//  idex_flush      out  1      clear ID/EX (bubble) at the next edge
//  idex_hold       out  1      ID/EX keeps its value
//  exmem_hold      out  1      EX/MEM keeps its value
//  mem_fault       out  1      one-cycle pulse: memory wait timed out
//  stall_cycles    out  CNT_W  cycles with pc_write==0
//  flush_events    out  CNT_W  cycles with ifid_flush==1
// BEHAVIOUR
//  FSM states: RUN, MEM_WAIT, FAULT. Reset -> RUN, wait_cnt=0, counters=0, mem_fault=0.
//  Outputs are combinational from state and inputs. In reset they decode as RUN with all inputs 0:
//  pc_write=1, ifid_write=1, all flushes and holds 0.
//  RUN:
//   - mem_req && !mem_ready -> MEM_WAIT next cycle. Freeze applies in this same cycle:
//     pc_write=ifid_write=0, idex_hold=exmem_hold=1, no flushes.
//   - else ex_branch_taken -> ifid_flush=1, idex_flush=1; PC loads the branch target.
//   - else load-use -> pc_write=0, ifid_write=0, idex_flush=1.
//     Load-use = ex_memtoreg && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)).
//   - Priority: memory freeze > branch flush > load-use. The branch discards the ID instruction,
//     so a simultaneous load-use must not stall.
//  MEM_WAIT:
//   - Full freeze, as in RUN with a pending access. wait_cnt increments every cycle.
//   - mem_ready=1 -> RUN; this cycle still frozen; wait_cnt=0.
//   - wait_cnt==MEM_TIMEOUT-1 && !mem_ready -> FAULT.
//   - Branch and load-use are not evaluated. EX is frozen, so they re-present after release.
//  FAULT:
//   - Exactly one cycle: mem_fault=1, ifid_flush=1, idex_flush=1, pc_write=0, exmem_hold=0.
//     EX/MEM drains the faulting access.
//   - wait_cnt=0, then -> RUN unconditionally.
//  mem_ready while !mem_req is ignored.
//  Counters: +1 per qualifying cycle; saturate at all-ones, with no wrap. They are not cleared by faults.
//  Async reset mid-MEM_WAIT returns to RUN immediately; the pending access is abandoned.
// STRUCTURE
//  riscv_pipe_pkg: hz_state_t enum {RUN, MEM_WAIT, FAULT}, REG_X0 = 5'd0.
//  One sub-module: sat_counter #(CNT_W) with inc and clear ports, instantiated twice for the perf counters.
//  FSM, wait counter and decode logic stay in pipe_hazard_ctrl.
// TESTING
//  1. ex_memtoreg=1, ex_rd=5, id_rs1=5, mem_req=0 -> pc_write=0, ifid_write=0, idex_flush=1; stall_cycles +1.
//  2. Same as 1 but ex_rd=0 or id_uses_rs2=0 with id_rs2=5, id_rs1=6 -> no stall, all enables 1.
//  3. ex_branch_taken=1 together with load-use -> ifid_flush=1, idex_flush=1, pc_write=1; flush_events +1.
//  4. mem_req=1, mem_ready low 3 cycles, then high -> 4 frozen cycles, RUN on the 5th; stall_cycles +4.
//  5. mem_req=1, mem_ready=0 held, MEM_TIMEOUT=4 -> mem_fault pulses in cycle 5 only, then RUN.
//  6. Assert reset in MEM_WAIT -> state RUN and counters 0 asynchronously; pc_write=1 before the next edge.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types and helpers for the RV32 pipeline control blocks.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A load in EX whose destination is read by the instruction in ID.
  function automatic logic load_use(
    input logic [4:0] rd,
    input logic       memtoreg,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       uses_rs2
  );
    return memtoreg && (rd != REG_X0) &&
           ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous reset and synchronous clear.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32 core: freezes on data-memory
// waits, flushes on taken branches, bubbles load-use hazards, times out stuck accesses.
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memtoreg,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned     WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall;
  logic              hazard;

  assign mem_stall = mem_req && !mem_ready;
  assign hazard    = load_use(ex_rd, ex_memtoreg, id_rs1, id_rs2, id_uses_rs2);

  // wait_cnt counts frozen cycles including the first one seen in RUN, so the
  // fault fires after exactly MEM_TIMEOUT frozen cycles without mem_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_req && mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= FAULT;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FAULT: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    idex_hold  = 1'b0;
    exmem_hold = 1'b0;
    mem_fault  = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
          end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
          exmem_hold = 1'b1;
        end
        FAULT: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          mem_fault  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (reset),
    .clear (1'b0),
    .inc   (!pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (reset),
    .clear (1'b0),
    .inc   (ifid_flush),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: decode table, directed memory-wait/timeout/reset
// sequences, and a randomized run against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned T = 4;
  localparam int unsigned W = 5;
  localparam int unsigned CMAX = (1 << W) - 1;

  // Output vector order: pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_hold, mem_fault
  localparam logic [6:0] O_IDLE   = 7'b1100000;
  localparam logic [6:0] O_LU     = 7'b0001000;
  localparam logic [6:0] O_BR     = 7'b1111000;
  localparam logic [6:0] O_FREEZE = 7'b0000110;
  localparam logic [6:0] O_FAULT  = 7'b0011001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs2 = 1'b0, ex_memtoreg = 1'b0, ex_branch_taken = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b0;
  logic pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_hold, mem_fault;
  logic [W-1:0] stall_cycles, flush_events;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memtoreg(ex_memtoreg), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
    .mem_fault(mem_fault), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic use2, m2r, br, req, rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[10];

  // Reference model state: waiting on memory, cycles already frozen, fault pending.
  bit m_waiting, m_fault;
  int unsigned m_waited, m_stalls, m_flushes;

  function automatic logic [6:0] outs();
    return {pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_hold, mem_fault};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                       input logic [4:0] rd, input logic m2r, input logic br,
                       input logic req, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = use2; ex_rd = rd;
    ex_memtoreg = m2r; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Apply one cycle of memory-only stimulus and check the decoded outputs.
  task automatic mem_cycle(input string name, input logic req, input logic rdy, input logic [6:0] exp);
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, req, rdy);
    #1 check(name, 32'(outs()), 32'(exp));
    @(negedge clk);
  endtask

  function automatic logic [6:0] model_out(input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic use2, input logic [4:0] rd,
                                           input logic m2r, input logic br,
                                           input logic req, input logic rdy);
    bit lu;
    lu = m2r && rd != 0 && (rd == rs1 || (use2 && rd == rs2));
    if (m_fault) return O_FAULT;
    if (m_waiting || (req && !rdy)) return O_FREEZE;
    if (br) return O_BR;
    if (lu) return O_LU;
    return O_IDLE;
  endfunction

  initial begin
    vecs[0] = '{rs1:5, rs2:0, rd:5, use2:0, m2r:1, br:0, req:0, rdy:0, exp:O_LU};
    vecs[1] = '{rs1:0, rs2:0, rd:0, use2:1, m2r:1, br:0, req:0, rdy:0, exp:O_IDLE};
    vecs[2] = '{rs1:6, rs2:5, rd:5, use2:0, m2r:1, br:0, req:0, rdy:0, exp:O_IDLE};
    vecs[3] = '{rs1:6, rs2:5, rd:5, use2:1, m2r:1, br:0, req:0, rdy:0, exp:O_LU};
    vecs[4] = '{rs1:5, rs2:5, rd:5, use2:1, m2r:0, br:0, req:0, rdy:0, exp:O_IDLE};
    vecs[5] = '{rs1:5, rs2:0, rd:5, use2:0, m2r:1, br:1, req:0, rdy:0, exp:O_BR};
    vecs[6] = '{rs1:1, rs2:2, rd:3, use2:1, m2r:0, br:1, req:0, rdy:0, exp:O_BR};
    vecs[7] = '{rs1:7, rs2:7, rd:7, use2:1, m2r:1, br:0, req:1, rdy:1, exp:O_LU};
    vecs[8] = '{rs1:1, rs2:2, rd:3, use2:0, m2r:0, br:0, req:0, rdy:1, exp:O_IDLE};
    vecs[9] = '{rs1:9, rs2:9, rd:9, use2:0, m2r:1, br:1, req:1, rdy:1, exp:O_BR};

    // Reset state
    #2;
    check("reset_outs", 32'(outs()), 32'(O_IDLE));
    check("reset_stall_cnt", 32'(stall_cycles), 0);
    check("reset_flush_cnt", 32'(flush_events), 0);
    @(negedge clk);
    reset = 1'b0;

    // Decode table, all in RUN
    foreach (vecs[i]) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].use2, vecs[i].rd,
            vecs[i].m2r, vecs[i].br, vecs[i].req, vecs[i].rdy);
      #1 check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      @(negedge clk);
    end
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("table_stall_cnt", 32'(stall_cycles), 3);
    check("table_flush_cnt", 32'(flush_events), 3);

    // Memory wait released by mem_ready after three low cycles
    do_reset();
    for (int i = 0; i < 3; i++) mem_cycle($sformatf("wait_freeze%0d", i), 1'b1, 1'b0, O_FREEZE);
    mem_cycle("wait_release", 1'b1, 1'b1, O_FREEZE);
    mem_cycle("wait_back_run", 1'b0, 1'b0, O_IDLE);
    #1;
    check("wait_stall_cnt", 32'(stall_cycles), 4);
    check("wait_flush_cnt", 32'(flush_events), 0);

    // Timeout: mem_ready never arrives
    do_reset();
    for (int i = 0; i < 4; i++) mem_cycle($sformatf("to_freeze%0d", i), 1'b1, 1'b0, O_FREEZE);
    mem_cycle("to_fault", 1'b1, 1'b0, O_FAULT);
    mem_cycle("to_back_run", 1'b0, 1'b0, O_IDLE);
    #1;
    check("to_stall_cnt", 32'(stall_cycles), 5);
    check("to_flush_cnt", 32'(flush_events), 1);

    // Asynchronous reset in the middle of a memory wait
    do_reset();
    mem_cycle("ar_enter", 1'b1, 1'b0, O_FREEZE);
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 check("ar_in_wait", 32'(outs()), 32'(O_FREEZE));
    check("ar_stall_before", 32'(stall_cycles), 1);
    #1 reset = 1'b1;
    #1;
    check("ar_outs", 32'(outs()), 32'(O_IDLE));
    check("ar_stall_cnt", 32'(stall_cycles), 0);
    @(negedge clk);
    reset = 1'b0;
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("ar_run_after", 32'(outs()), 32'(O_IDLE));

    // Randomized run against the reference model
    do_reset();
    m_waiting = 0; m_fault = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
    for (int c = 0; c < 400; c++) begin
      logic [4:0] rs1, rs2, rd;
      logic use2, m2r, br, req, rdy;
      logic [6:0] exp;
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      use2 = 1'($urandom_range(0, 1));
      m2r  = 1'($urandom_range(0, 1));
      br   = ($urandom_range(0, 5) == 0);
      if (m_waiting) begin
        req = 1'b1;
        rdy = ($urandom_range(0, 3) == 0);
      end else begin
        req = ($urandom_range(0, 3) == 0);
        rdy = 1'($urandom_range(0, 1));
      end
      drive(rs1, rs2, use2, rd, m2r, br, req, rdy);
      exp = model_out(rs1, rs2, use2, rd, m2r, br, req, rdy);
      #1;
      check($sformatf("rnd%0d_outs", c), 32'(outs()), 32'(exp));
      check($sformatf("rnd%0d_stall", c), 32'(stall_cycles), m_stalls);
      check($sformatf("rnd%0d_flush", c), 32'(flush_events), m_flushes);
      if (!exp[6] && m_stalls < CMAX) m_stalls++;
      if (exp[4] && m_flushes < CMAX) m_flushes++;
      if (m_fault) begin
        m_fault = 0;
      end else if (m_waiting) begin
        if (req && rdy) m_waiting = 0;
        else if (m_waited + 1 == T) begin
          m_waiting = 0;
          m_fault = 1;
        end else m_waited++;
      end else if (req && !rdy) begin
        m_waiting = 1;
        m_waited = 1;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
